// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: IF-stage fetch sequencer owning the PC, one outstanding imem request and a 2-entry skid buffer
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_halt,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    input  logic        i_ready
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;
    state_e      state_q;
    logic [31:0] fpc_q, fpc_d, infl_pc_q, infl_pc_d;
    logic        infl_q, infl_d;
    logic [1:0]  cnt_q, cnt_d, cnt_pop;
    logic [63:0] e0_q, e0_d, e1_q, e1_d, ret;
    logic        pop, push;
    assign pop         = (cnt_q != 2'd0) && i_ready && !i_redirect;
    assign push        = infl_q && !i_redirect;
    assign cnt_pop     = cnt_q - {1'b0, pop};
    assign o_imem_req  = (state_q == RUN) && !i_halt && !i_redirect &&
                         ({1'b0, cnt_pop} + {2'b0, infl_q} < 3'd2);
    assign o_imem_addr = fpc_q;
    assign o_valid     = cnt_q != 2'd0;
    assign o_pc        = e0_q[63:32];
    assign o_instr     = e0_q[31:0];
    assign ret         = {infl_pc_q, i_imem_rdata};
    // Entries at or beyond cnt are kept zero so the head reads 0 when empty
    always_comb begin
        fpc_d     = i_redirect ? (i_redirect_pc & ~32'd3) : o_imem_req ? fpc_q + 32'd4 : fpc_q;
        infl_d    = o_imem_req;
        infl_pc_d = o_imem_req ? fpc_q : infl_pc_q;
        cnt_d     = i_redirect ? 2'd0 : cnt_pop + {1'b0, push};
        e0_d      = i_redirect ? 64'd0 : (push && cnt_pop == 2'd0) ? ret : pop ? e1_q : e0_q;
        e1_d      = i_redirect ? 64'd0 : (push && cnt_pop == 2'd1) ? ret : pop ? 64'd0 : e1_q;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= BOOT;
            fpc_q     <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= 32'd0;
            cnt_q     <= 2'd0;
            e0_q      <= 64'd0;
            e1_q      <= 64'd0;
        end else begin
            state_q   <= i_halt ? HALT : RUN;
            fpc_q     <= fpc_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
            cnt_q     <= cnt_d;
            e0_q      <= e0_d;
            e1_q      <= e1_d;
        end
    end
    assert property (@(posedge i_clk) disable iff (!i_rst_n) !(push && cnt_pop == 2'd2));
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed vector table, corner sequences and random traffic against a queue-based model
module tb_if_fetch_ctrl;
    localparam logic [31:0] RPC = 32'h0000_0000;
    logic        i_clk = 1'b0, i_rst_n = 1'b0;
    logic        o_imem_req, o_valid;
    logic [31:0] o_imem_addr, o_instr, o_pc;
    logic [31:0] i_imem_rdata = 32'd0, i_redirect_pc = 32'd0;
    logic        i_redirect = 1'b0, i_halt = 1'b0, i_ready = 1'b0;

    if_fetch_ctrl #(.RESET_PC(RPC)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_rdata(i_imem_rdata), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .i_halt(i_halt), .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc), .i_ready(i_ready)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {logic [31:0] pc; logic [31:0] instr;} ent_t;
    typedef struct {
        logic rd; logic [31:0] rpc; logic h; logic rdy;
        logic req; logic [31:0] addr; logic v; logic [31:0] pc;
    } vec_t;

    int n_chk = 0, n_fail = 0;
    ent_t q[$];
    logic [31:0] m_fpc, m_ipc, prev_addr;
    logic        m_infl, m_boot, m_ph;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_fpc = RPC; m_ipc = 32'd0; m_infl = 1'b0; m_boot = 1'b1; m_ph = 1'b0;
        prev_addr = RPC;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_req"}, {31'd0, o_imem_req}, 32'd0);
        chk({tag, "_addr"}, o_imem_addr, RPC);
        chk({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
        chk({tag, "_pc"}, o_pc, 32'd0);
        chk({tag, "_instr"}, o_instr, 32'd0);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0; i_redirect = 1'b0; i_halt = 1'b0; i_ready = 1'b1;
        model_reset();
        @(negedge i_clk);
        reset_checks("rst");
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
    endtask

    // One cycle: drive at posedge+1, compare at negedge, advance the model for the coming edge
    task automatic step(input logic rd, input logic [31:0] rpc, input logic h, input logic rdy);
        int  n;
        logic mpop, mreq, run_ok;
        i_redirect = rd; i_redirect_pc = rpc; i_halt = h; i_ready = rdy;
        i_imem_rdata = mem(prev_addr);
        @(negedge i_clk);
        n      = q.size();
        run_ok = !m_boot && !m_ph;
        mpop   = n > 0 && rdy && !rd;
        mreq   = run_ok && !h && !rd && (n - int'(mpop) + int'(m_infl)) < 2;
        chk("req", {31'd0, o_imem_req}, {31'd0, mreq});
        chk("addr", o_imem_addr, m_fpc);
        chk("valid", {31'd0, o_valid}, {31'd0, n > 0});
        chk("pc", o_pc, n > 0 ? q[0].pc : 32'd0);
        chk("instr", o_instr, n > 0 ? q[0].instr : 32'd0);
        s_req = o_imem_req; s_addr = o_imem_addr; s_valid = o_valid; s_pc = o_pc; s_instr = o_instr;
        prev_addr = o_imem_addr;
        if (rd) begin
            q.delete(); m_infl = 1'b0; m_fpc = rpc & ~32'd3;
        end else begin
            if (mpop) void'(q.pop_front());
            if (m_infl) q.push_back({m_ipc, mem(m_ipc)});
            if (mreq) begin m_ipc = m_fpc; m_fpc = m_fpc + 32'd4; end
            m_infl = mreq;
        end
        m_boot = 1'b0; m_ph = h;
        @(posedge i_clk); #1;
    endtask

    function automatic vec_t mk(input logic rd, input logic [31:0] rpc, input logic h, input logic rdy,
                                input logic req, input logic [31:0] addr, input logic v, input logic [31:0] pc);
        vec_t t;
        t.rd = rd; t.rpc = rpc; t.h = h; t.rdy = rdy; t.req = req; t.addr = addr; t.v = v; t.pc = pc;
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tv[24];
        logic [31:0] wexp[4];
        logic [31:0] wgot[$];
        tv[0]  = mk(0, 0, 0, 1, 0, 32'h00, 0, 32'h00);
        tv[1]  = mk(0, 0, 0, 1, 1, 32'h00, 0, 32'h00);
        tv[2]  = mk(0, 0, 0, 1, 1, 32'h04, 0, 32'h00);
        tv[3]  = mk(0, 0, 0, 1, 1, 32'h08, 1, 32'h00);
        tv[4]  = mk(0, 0, 0, 1, 1, 32'h0C, 1, 32'h04);
        for (int i = 5; i < 10; i++) tv[i] = mk(0, 0, 0, 0, 0, 32'h10, 1, 32'h08);
        tv[10] = mk(0, 0, 0, 1, 1, 32'h10, 1, 32'h08);
        tv[11] = mk(0, 0, 0, 1, 1, 32'h14, 1, 32'h0C);
        tv[12] = mk(1, 32'h26, 0, 1, 0, 32'h18, 1, 32'h10);
        tv[13] = mk(0, 0, 0, 1, 1, 32'h24, 0, 32'h00);
        tv[14] = mk(0, 0, 0, 1, 1, 32'h28, 0, 32'h00);
        tv[15] = mk(0, 0, 0, 1, 1, 32'h2C, 1, 32'h24);
        tv[16] = mk(0, 0, 1, 1, 0, 32'h30, 1, 32'h28);
        tv[17] = mk(0, 0, 1, 1, 0, 32'h30, 1, 32'h2C);
        tv[18] = mk(0, 0, 1, 1, 0, 32'h30, 0, 32'h00);
        tv[19] = mk(0, 0, 1, 1, 0, 32'h30, 0, 32'h00);
        tv[20] = mk(0, 0, 0, 1, 0, 32'h30, 0, 32'h00);
        tv[21] = mk(0, 0, 0, 1, 1, 32'h30, 0, 32'h00);
        tv[22] = mk(0, 0, 0, 1, 1, 32'h34, 0, 32'h00);
        tv[23] = mk(0, 0, 0, 1, 1, 32'h38, 1, 32'h30);
        wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

        do_reset();
        for (int i = 0; i < 24; i++) begin
            step(tv[i].rd, tv[i].rpc, tv[i].h, tv[i].rdy);
            chk("tv_req", {31'd0, s_req}, {31'd0, tv[i].req});
            chk("tv_addr", s_addr, tv[i].addr);
            chk("tv_valid", {31'd0, s_valid}, {31'd0, tv[i].v});
            chk("tv_pc", s_pc, tv[i].pc);
            chk("tv_instr", s_instr, tv[i].v ? mem(tv[i].pc) : 32'd0);
        end

        step(0, 0, 1, 1); step(0, 0, 1, 1);
        step(1, 32'h100, 1, 1); step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
        chk("halt_redir_valid", {31'd0, s_valid}, 32'd1);
        chk("halt_redir_pc", s_pc, 32'h100);

        step(1, 32'hFFFF_FFF8, 0, 1);
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0, 1);
            if (s_valid && wgot.size() < 4) wgot.push_back(s_pc);
        end
        chk("wrap_count", wgot.size(), 32'd4);
        for (int k = 0; k < 4; k++) chk("wrap_pc", k < wgot.size() ? wgot[k] : 32'hDEAD_DEAD, wexp[k]);

        for (int k = 0; k < 3; k++) step(0, 0, 0, 1);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
        chk("pre_rst_valid", {31'd0, o_valid}, 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        reset_checks("async");
        model_reset();
        @(posedge i_clk); #1;
        i_ready = 1'b1;
        @(negedge i_clk);
        reset_checks("hold");
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 0, 1);
            if (k == 1) chk("reboot_addr", s_addr, RPC);
            if (k == 3) chk("reboot_first_pc", {s_pc[31:1], s_valid}, {RPC[31:1], 1'b1});
        end

        begin
            logic h = 1'b0;
            for (int k = 0; k < 3000; k++) begin
                logic        rd, rdy;
                logic [31:0] rpc;
                if ($urandom_range(7) == 0) h = ~h;
                rd  = $urandom_range(19) == 0;
                rpc = $urandom_range(3) == 0 ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : $urandom;
                rdy = $urandom_range(3) != 0;
                step(rd, rpc, h, rdy);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
